// File: rtl/aes_gcm_ghash_tag_stage.sv
// aes_gcm_ghash_tag_stage
//
// Last stage of the AES-GCM pipeline. It takes the keystream, the hash
// subkey H and E(K, J0) from the final AES round stage. It XORs the keystream
// with the plaintext to form ciphertext and accumulates GHASH over the AAD,
// ciphertext and length blocks of one instance. On the length block it emits
// the authentication tag.
//
// The block runs as two register stages, so each block has a two-cycle
// latency. One block is accepted per cycle with no stalls.
//
// Ports (all 128-bit buses are [0:127], bit 0 is the GCM MSB):
//   clk, rst_n        clock, asynchronous active-low reset
//   i_phase           00 bubble, 01 AAD, 10 text, 11 length block
//   i_new_instance    first block of a new instance (non-bubble only)
//   i_plain_text      plaintext block
//   i_aad             AAD block
//   i_instance_size   len(A) || len(C) in bits
//   i_valid_bytes     valid leading bytes of an AAD/text block (0 or >=16: all)
//   i_h               hash subkey H
//   i_encrypted_cb    keystream E(K, CB) for the current text block
//   i_encrypted_j0    E(K, J0)
//   o_cipher_text     masked ciphertext; holds between strobes
//   o_cipher_valid    one-cycle strobe for o_cipher_text
//   o_tag             GHASH xor E(K, J0); holds until the next tag
//   o_tag_valid       one-cycle strobe for o_tag
//   o_error           sticky ordering error, cleared by a new instance
//   o_block_count     text blocks processed in the current instance
//
// state  | meaning
// IDLE   | no instance open; only a new-instance block is legal
// AAD    | AAD blocks being hashed; AAD, text or length may follow
// TEXT   | text blocks being hashed; text or length may follow

module aes_gcm_ghash_tag_stage (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   i_phase,
    input  logic         i_new_instance,
    input  logic [0:127] i_plain_text,
    input  logic [0:127] i_aad,
    input  logic [0:127] i_instance_size,
    input  logic [4:0]   i_valid_bytes,
    input  logic [0:127] i_h,
    input  logic [0:127] i_encrypted_cb,
    input  logic [0:127] i_encrypted_j0,
    output logic [0:127] o_cipher_text,
    output logic         o_cipher_valid,
    output logic [0:127] o_tag,
    output logic         o_tag_valid,
    output logic         o_error,
    output logic [31:0]  o_block_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_AAD  = 2'b01,
        ST_TEXT = 2'b10
    } state_t;

    localparam logic [1:0] PH_BUBBLE = 2'b00;
    localparam logic [1:0] PH_AAD    = 2'b01;
    localparam logic [1:0] PH_TEXT   = 2'b10;

    // Reduction constant R = 11100001 || 0^120.
    localparam logic [0:127] GF_R = 128'he1000000_00000000_00000000_00000000;

    // Multiply in GF(2^128) with GCM bit ordering. With [0:127] vectors a
    // right shift moves bits toward index 127, which matches the rightshift
    // in the GCM definition.
    function automatic logic [0:127] gf_mult(input logic [0:127] x,
                                             input logic [0:127] y);
        logic [0:127] z;
        logic [0:127] v;
        z = '0;
        v = y;
        for (int i = 0; i < 128; i++) begin
            if (x[i]) begin
                z = z ^ v;
            end
            if (v[127]) begin
                v = (v >> 1) ^ GF_R;
            end else begin
                v = v >> 1;
            end
        end
        return z;
    endfunction

    // ---------------- stage A: input register ----------------
    logic [1:0]   a_phase;
    logic         a_new;
    logic [0:127] a_pt;
    logic [0:127] a_aad;
    logic [0:127] a_size;
    logic [4:0]   a_vb;
    logic [0:127] a_ecb;
    logic [0:127] r_hkey;
    logic [0:127] r_j0;

    // r_hkey and r_j0 load in the same edge as the new-instance block, so
    // stage B of that block already sees the fresh H and E(J0). A block still
    // in stage B at that edge has used the previous values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_phase <= PH_BUBBLE;
            a_new   <= 1'b0;
            a_pt    <= '0;
            a_aad   <= '0;
            a_size  <= '0;
            a_vb    <= '0;
            a_ecb   <= '0;
            r_hkey  <= '0;
            r_j0    <= '0;
        end else begin
            a_phase <= i_phase;
            a_new   <= i_new_instance;
            a_pt    <= i_plain_text;
            a_aad   <= i_aad;
            a_size  <= i_instance_size;
            a_vb    <= i_valid_bytes;
            a_ecb   <= i_encrypted_cb;
            if (i_phase != PH_BUBBLE && i_new_instance) begin
                r_hkey <= i_h;
                r_j0   <= i_encrypted_j0;
            end
        end
    end

    // ---------------- stage B: compute ----------------
    state_t       state;
    state_t       state_next;
    logic [0:127] y;
    logic [0:127] y_base;
    logic [0:127] y_next;
    logic [0:127] mask;
    logic [0:127] ct;
    logic [0:127] x;
    logic         accept;
    logic         flag_err;

    always_comb begin
        if (a_vb == 5'd0 || a_vb >= 5'd16) begin
            mask = '1;
        end else begin
            // Leading a_vb bytes are ones, the rest are zeros.
            mask = ~({128{1'b1}} >> {a_vb, 3'b000});
        end

        ct = (a_pt ^ a_ecb) & mask;

        case (a_phase)
            PH_AAD:  x = a_aad & mask;
            PH_TEXT: x = ct;
            default: x = a_size;
        endcase

        y_base = a_new ? '0 : y;
        y_next = gf_mult(y_base ^ x, r_hkey);

        // A new-instance block is decoded as if the FSM were in IDLE.
        accept     = 1'b0;
        flag_err   = 1'b0;
        state_next = state;
        if (a_phase != PH_BUBBLE) begin
            if (!a_new && state == ST_IDLE) begin
                flag_err = 1'b1;
            end else if (!a_new && state == ST_TEXT && a_phase == PH_AAD) begin
                flag_err = 1'b1;
            end else begin
                accept = 1'b1;
                case (a_phase)
                    PH_AAD:  state_next = ST_AAD;
                    PH_TEXT: state_next = ST_TEXT;
                    default: state_next = ST_IDLE;
                endcase
            end
        end
    end

    // ---------------- stage B: register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            y              <= '0;
            o_cipher_text  <= '0;
            o_cipher_valid <= 1'b0;
            o_tag          <= '0;
            o_tag_valid    <= 1'b0;
            o_error        <= 1'b0;
            o_block_count  <= '0;
        end else begin
            o_cipher_valid <= 1'b0;
            o_tag_valid    <= 1'b0;
            if (a_phase != PH_BUBBLE) begin
                if (a_new) begin
                    o_error       <= 1'b0;
                    o_block_count <= '0;
                end
                if (flag_err) begin
                    o_error <= 1'b1;
                end
                if (accept) begin
                    y     <= y_next;
                    state <= state_next;
                    if (a_phase == PH_TEXT) begin
                        o_cipher_text  <= ct;
                        o_cipher_valid <= 1'b1;
                        o_block_count  <= (a_new ? 32'd0 : o_block_count) + 32'd1;
                    end else if (a_phase == 2'b11) begin
                        o_tag       <= y_next ^ r_j0;
                        o_tag_valid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_gcm_ghash_tag_stage.sv
module tb_aes_gcm_ghash_tag_stage;

    logic         clk;
    logic         rst_n;
    logic [1:0]   i_phase;
    logic         i_new_instance;
    logic [0:127] i_plain_text;
    logic [0:127] i_aad;
    logic [0:127] i_instance_size;
    logic [4:0]   i_valid_bytes;
    logic [0:127] i_h;
    logic [0:127] i_encrypted_cb;
    logic [0:127] i_encrypted_j0;
    logic [0:127] o_cipher_text;
    logic         o_cipher_valid;
    logic [0:127] o_tag;
    logic         o_tag_valid;
    logic         o_error;
    logic [31:0]  o_block_count;

    int total = 0;
    int bad   = 0;

    localparam logic [0:127] H_TC   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [0:127] J0_TC  = 128'h58e2fccefa7e3061367f1d57a4e7455a;
    localparam logic [0:127] ECB2   = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam logic [0:127] TAG2   = 128'hab6e47d42cec13bdf53a67b21257bddf;
    localparam logic [0:127] SIZE2  = 128'h00000000000000000000000000000080;
    localparam logic [0:127] JUNK   = 128'hdeadbeef0badf00dcafebabe12345678;
    localparam logic [0:127] ONE    = 128'h80000000000000000000000000000000;
    localparam logic [0:127] ZERO   = 128'h0;
    localparam logic [0:127] ALLF   = 128'hffffffffffffffffffffffffffffffff;

    aes_gcm_ghash_tag_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_phase         (i_phase),
        .i_new_instance  (i_new_instance),
        .i_plain_text    (i_plain_text),
        .i_aad           (i_aad),
        .i_instance_size (i_instance_size),
        .i_valid_bytes   (i_valid_bytes),
        .i_h             (i_h),
        .i_encrypted_cb  (i_encrypted_cb),
        .i_encrypted_j0  (i_encrypted_j0),
        .o_cipher_text   (o_cipher_text),
        .o_cipher_valid  (o_cipher_valid),
        .o_tag           (o_tag),
        .o_tag_valid     (o_tag_valid),
        .o_error         (o_error),
        .o_block_count   (o_block_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [0:127] obs, input logic [0:127] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one block at a falling edge and move to the next falling edge.
    // Inputs not used by the phase carry junk to catch wrong source selection.
    task automatic blk(input logic [1:0] ph, input logic nw, input logic [0:127] data,
                       input logic [0:127] ecb, input logic [4:0] vb,
                       input logic [0:127] h, input logic [0:127] j0);
        i_phase         = ph;
        i_new_instance  = nw;
        i_plain_text    = (ph == 2'b10) ? data : JUNK;
        i_aad           = (ph == 2'b01) ? data : JUNK;
        i_instance_size = (ph == 2'b11) ? data : JUNK;
        i_encrypted_cb  = ecb;
        i_valid_bytes   = vb;
        i_h             = h;
        i_encrypted_j0  = j0;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            blk(2'b00, 1'b1, JUNK, JUNK, 5'd3, JUNK, JUNK);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        i_phase = 2'b00; i_new_instance = 1'b0; i_plain_text = '0; i_aad = '0;
        i_instance_size = '0; i_valid_bytes = '0; i_h = '0; i_encrypted_cb = '0;
        i_encrypted_j0 = '0;
        #1;
        chk("rst_tag", o_tag, ZERO);
        chk("rst_ct", o_cipher_text, ZERO);
        chk("rst_tag_valid", 128'(o_tag_valid), ZERO);
        chk("rst_ct_valid", 128'(o_cipher_valid), ZERO);
        chk("rst_error", 128'(o_error), ZERO);
        chk("rst_count", 128'(o_block_count), ZERO);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // TC1: empty AAD and text.
        blk(2'b11, 1'b1, ZERO, JUNK, 5'd0, H_TC, J0_TC);
        idle(1);
        chk("tc1_tag_valid", 128'(o_tag_valid), 128'd1);
        chk("tc1_tag", o_tag, J0_TC);
        chk("tc1_ct_valid", 128'(o_cipher_valid), ZERO);
        chk("tc1_error", 128'(o_error), ZERO);
        idle(1);
        chk("tc1_tag_pulse", 128'(o_tag_valid), ZERO);
        chk("tc1_tag_hold", o_tag, J0_TC);

        // TC2 with bubbles between the blocks.
        blk(2'b10, 1'b1, ZERO, ECB2, 5'd16, H_TC, J0_TC);
        idle(1);
        chk("tc2_ct_valid", 128'(o_cipher_valid), 128'd1);
        chk("tc2_ct", o_cipher_text, ECB2);
        chk("tc2_count", 128'(o_block_count), 128'd1);
        idle(1);
        blk(2'b11, 1'b0, SIZE2, JUNK, 5'd0, JUNK, JUNK);
        idle(1);
        chk("tc2_tag_valid", 128'(o_tag_valid), 128'd1);
        chk("tc2_tag", o_tag, TAG2);
        chk("tc2_ct_pulse", 128'(o_cipher_valid), ZERO);
        chk("tc2_ct_hold", o_cipher_text, ECB2);

        // Back-to-back: TC2 then TC1 in consecutive cycles.
        blk(2'b10, 1'b1, ZERO, ECB2, 5'd0, H_TC, J0_TC);
        blk(2'b11, 1'b0, SIZE2, JUNK, 5'd0, JUNK, JUNK);
        chk("b2b_ct_valid", 128'(o_cipher_valid), 128'd1);
        chk("b2b_ct", o_cipher_text, ECB2);
        blk(2'b11, 1'b1, ZERO, JUNK, 5'd0, H_TC, J0_TC);
        chk("b2b_tag2_valid", 128'(o_tag_valid), 128'd1);
        chk("b2b_tag2", o_tag, TAG2);
        idle(1);
        chk("b2b_tag1_valid", 128'(o_tag_valid), 128'd1);
        chk("b2b_tag1", o_tag, J0_TC);
        idle(1);
        chk("b2b_quiet", 128'(o_tag_valid), ZERO);

        // H = 1 makes GHASH a plain XOR of the masked blocks.
        // AAD 2 bytes 1122, text 0f.., size 0x10 / 0x80, J0 = 0.
        blk(2'b01, 1'b1, 128'h112233445566778899aabbccddeeff00, JUNK, 5'd2, ONE, ZERO);
        blk(2'b10, 1'b0, ZERO, 128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f, 5'd0, JUNK, JUNK);
        chk("aad_no_strobe", 128'(o_cipher_valid), ZERO);
        blk(2'b11, 1'b0, 128'h00000000000000100000000000000080, JUNK, 5'd0, JUNK, JUNK);
        chk("aad_text_ct", o_cipher_text, 128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f);
        chk("aad_text_count", 128'(o_block_count), 128'd1);
        idle(1);
        chk("aad_tag_valid", 128'(o_tag_valid), 128'd1);
        chk("aad_tag", o_tag, 128'h1e2d0f0f0f0f0f1f0f0f0f0f0f0f0f8f);

        // Partial block: 4 valid bytes, GHASH over the masked block (H = 1).
        blk(2'b10, 1'b1, ALLF, ZERO, 5'd4, ONE, ZERO);
        idle(1);
        chk("part_ct", o_cipher_text, 128'hffffffff000000000000000000000000);
        blk(2'b11, 1'b0, 128'h00000000000000000000000000000020, JUNK, 5'd0, JUNK, JUNK);
        idle(1);
        chk("part_tag", o_tag, 128'hffffffff000000000000000000000020);

        // Ordering error: AAD after text.
        blk(2'b10, 1'b1, ZERO, ECB2, 5'd16, H_TC, J0_TC);
        blk(2'b01, 1'b0, ALLF, JUNK, 5'd16, JUNK, JUNK);
        chk("ord_text_count", 128'(o_block_count), 128'd1);
        idle(1);
        chk("ord_error", 128'(o_error), 128'd1);
        chk("ord_no_ct", 128'(o_cipher_valid), ZERO);
        chk("ord_no_tag", 128'(o_tag_valid), ZERO);
        chk("ord_count_hold", 128'(o_block_count), 128'd1);
        blk(2'b11, 1'b1, ZERO, JUNK, 5'd0, H_TC, J0_TC);
        idle(1);
        chk("ord_cleared", 128'(o_error), ZERO);
        chk("ord_tc1_tag", o_tag, J0_TC);
        chk("ord_tc1_valid", 128'(o_tag_valid), 128'd1);

        // Reset mid-instance.
        blk(2'b10, 1'b1, ZERO, ECB2, 5'd16, H_TC, J0_TC);
        idle(1);
        chk("mid_ct_valid", 128'(o_cipher_valid), 128'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ct", o_cipher_text, ZERO);
        chk("mid_rst_tag", o_tag, ZERO);
        chk("mid_rst_count", 128'(o_block_count), ZERO);
        chk("mid_rst_ct_valid", 128'(o_cipher_valid), ZERO);
        @(negedge clk);
        rst_n = 1'b1;
        blk(2'b11, 1'b0, SIZE2, JUNK, 5'd0, JUNK, JUNK);
        idle(1);
        chk("post_rst_error", 128'(o_error), 128'd1);
        chk("post_rst_no_tag", 128'(o_tag_valid), ZERO);
        chk("post_rst_tag", o_tag, ZERO);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
